// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register word addresses,
// CTRL bit positions and the priority pointer wrap helper.
package irq_ctrl_pkg;

   localparam int IRQ_MAX_SRC = 6;

   typedef enum logic [2:0] {
      IRQ_MASK = 3'd0,
      IRQ_MODE = 3'd1,
      IRQ_PEND = 3'd2,
      IRQ_CTRL = 3'd3,
      IRQ_VEC  = 3'd4,
      IRQ_ACK  = 3'd5
   } irq_reg_e;

   localparam int CTRL_EN  = 0;
   localparam int CTRL_ROT = 1;

   // Next pointer after servicing source n, wrapping inside the active sources.
   function automatic logic [2:0] irq_wrap_inc(input logic [2:0] n, input int n_src);
      if (int'(n) + 1 >= n_src) return 3'd0;
      return n + 3'd1;
   endfunction

endpackage

// File: rtl/irq_rr_select.sv
// Combinational rotating-priority finder: first set bit of eff_i at or above
// ptr_i, wrapping modulo N.
module irq_rr_select #(
   parameter int N = 6
) (
   input  logic [5:0] eff_i,
   input  logic [2:0] ptr_i,
   output logic [2:0] idx_o,
   output logic       valid_o
);

   int j;

   always_comb begin
      idx_o   = '0;
      valid_o = |eff_i;
      j       = 0;
      // Walk the ring backwards so the candidate nearest ptr_i is written last.
      for (int k = N - 1; k >= 0; k--) begin
         j = (int'(ptr_i) + k) % N;
         if (eff_i[j]) idx_o = 3'(j);
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Programmable interrupt controller: synchronises, latches, masks and
// prioritises up to six device interrupt lines onto hwirq[7:2].
module irq_ctrl #(
   parameter int N_SRC       = 6,
   parameter int SYNC_STAGES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  addr,
   input  logic        write_enable,
   input  logic [31:0] write_data,
   output logic [31:0] read_result,
   input  logic [5:0]  irq_src,
   output logic [7:2]  hwirq
);

   import irq_ctrl_pkg::*;

   localparam logic [5:0] SRC_MSK = 6'((1 << N_SRC) - 1);

   logic [SYNC_STAGES-1:0][5:0] sync_q;
   logic [5:0] prev_q, mask_q, mode_q, pend_q, pend_d, hwirq_q;
   logic       en_q, rot_q;
   logic [2:0] ptr_q, ptr_d;

   logic [5:0] src_s, rise, w1c, ack_oh, pend_view, eff;
   logic       wr_mask, wr_mode, wr_pend, wr_ctrl, wr_ack, ack_ok;
   logic [2:0] ack_idx, vec_idx;
   logic       vec_valid;
   logic       unused_wdata;

   assign unused_wdata = ^write_data[31:6];

   assign wr_mask = write_enable && (addr == IRQ_MASK);
   assign wr_mode = write_enable && (addr == IRQ_MODE);
   assign wr_pend = write_enable && (addr == IRQ_PEND);
   assign wr_ctrl = write_enable && (addr == IRQ_CTRL);
   assign wr_ack  = write_enable && (addr == IRQ_ACK);

   assign ack_idx = write_data[2:0];
   assign ack_ok  = wr_ack && (int'(ack_idx) < N_SRC);
   assign ack_oh  = ack_ok ? (6'b1 << ack_idx) : 6'b0;
   assign w1c     = wr_pend ? write_data[5:0] : 6'b0;

   assign src_s = sync_q[SYNC_STAGES-1];
   assign rise  = src_s & ~prev_q;

   // Only edge-mode bits hold a latch; a new edge beats a same-cycle clear.
   // Level bits keep it at 0, so switching level->edge starts from cleared.
   assign pend_d    = mode_q & SRC_MSK & (rise | (pend_q & ~(w1c | ack_oh)));
   assign pend_view = ((mode_q & pend_q) | (~mode_q & src_s)) & SRC_MSK;
   assign eff       = pend_view & mask_q;

   always_comb begin
      ptr_d = ptr_q;
      if (wr_ctrl && !write_data[CTRL_ROT]) ptr_d = 3'd0;
      else if (ack_ok && rot_q)             ptr_d = irq_wrap_inc(ack_idx, N_SRC);
   end

   irq_rr_select #(.N(N_SRC)) u_sel (
      .eff_i   (eff),
      .ptr_i   (ptr_q),
      .idx_o   (vec_idx),
      .valid_o (vec_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         prev_q  <= '0;
         mask_q  <= '0;
         mode_q  <= '0;
         pend_q  <= '0;
         en_q    <= 1'b0;
         rot_q   <= 1'b0;
         ptr_q   <= '0;
         hwirq_q <= '0;
      end else begin
         sync_q[0] <= irq_src;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         prev_q  <= src_s;
         pend_q  <= pend_d;
         ptr_q   <= ptr_d;
         hwirq_q <= en_q ? eff : 6'b0;
         if (wr_mask) mask_q <= write_data[5:0] & SRC_MSK;
         if (wr_mode) mode_q <= write_data[5:0] & SRC_MSK;
         if (wr_ctrl) begin
            en_q  <= write_data[CTRL_EN];
            rot_q <= write_data[CTRL_ROT];
         end
      end
   end

   assign hwirq = hwirq_q;

   always_comb begin
      read_result = '0;
      case (addr)
         IRQ_MASK: read_result[5:0] = mask_q;
         IRQ_MODE: read_result[5:0] = mode_q;
         IRQ_PEND: read_result[5:0] = pend_view;
         IRQ_CTRL: read_result[1:0] = {rot_q, en_q};
         IRQ_VEC:  if (vec_valid) read_result = {1'b1, 28'd0, vec_idx};
         default:  read_result = '0;
      endcase
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: random and directed bus/irq traffic checked
// against a queue-based behavioural model, plus hand-derived spot checks.
module tb_irq_ctrl;

   localparam int N  = 6;
   localparam int SY = 1;
   localparam bit [5:0] LOWM = 6'((1 << N) - 1);

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  addr;
   logic        write_enable;
   logic [31:0] write_data;
   logic [31:0] read_result;
   logic [5:0]  irq_src;
   logic [7:2]  hwirq;

   always #5 clk = ~clk;

   irq_ctrl #(.N_SRC(N), .SYNC_STAGES(SY)) dut (
      .clk          (clk),
      .rst          (rst),
      .addr         (addr),
      .write_enable (write_enable),
      .write_data   (write_data),
      .read_result  (read_result),
      .irq_src      (irq_src),
      .hwirq        (hwirq)
   );

   typedef struct packed {
      logic [31:0] rd;
      logic [5:0]  hw;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Behavioural model: register values, edge latches, and a history of
   // sampled irq_src values (index 0 = newest sample).
   bit [5:0] m_mask, m_mode, m_pend, m_hw;
   bit       m_en, m_rot;
   int       m_ptr;
   bit [5:0] smp[$];
   bit [5:0] src_cur;

   function automatic bit [5:0] m_view();
      bit [5:0] v = '0;
      for (int i = 0; i < N; i++) v[i] = m_mode[i] ? m_pend[i] : smp[SY-1][i];
      return v;
   endfunction

   function automatic bit [31:0] m_vec();
      bit [5:0] eff = m_view() & m_mask;
      for (int k = 0; k < N; k++) begin
         int j = (m_ptr + k) % N;
         if (eff[j]) return {1'b1, 28'd0, 3'(j)};
      end
      return 32'd0;
   endfunction

   function automatic bit [31:0] m_read(bit [2:0] a);
      case (a)
         3'd0:    return {26'd0, m_mask};
         3'd1:    return {26'd0, m_mode};
         3'd2:    return {26'd0, m_view()};
         3'd3:    return {30'd0, m_rot, m_en};
         3'd4:    return m_vec();
         default: return 32'd0;
      endcase
   endfunction

   task automatic m_reset();
      m_mask = '0; m_mode = '0; m_pend = '0; m_hw = '0;
      m_en = 0; m_rot = 0; m_ptr = 0;
      smp.delete();
      for (int i = 0; i <= SY; i++) smp.push_back(6'd0);
   endtask

   task automatic m_edge(bit r, bit [2:0] a, bit we, bit [31:0] wd, bit [5:0] s);
      bit [5:0] cur, prv, new_hw;
      if (r) begin
         m_reset();
         return;
      end
      cur    = smp[SY-1];
      prv    = smp[SY];
      new_hw = m_en ? (m_view() & m_mask) : 6'd0;
      for (int i = 0; i < N; i++) begin
         if (m_mode[i]) begin
            bit rising = cur[i] && !prv[i];
            bit clr    = we && ((a == 3'd2 && wd[i]) || (a == 3'd5 && int'(wd[2:0]) == i));
            m_pend[i]  = rising || (m_pend[i] && !clr);
         end else begin
            m_pend[i] = 1'b0;
         end
      end
      if (we) begin
         case (a)
            3'd0: m_mask = wd[5:0] & LOWM;
            3'd1: m_mode = wd[5:0] & LOWM;
            3'd3: begin
               m_en = wd[0];
               if (!wd[1]) m_ptr = 0;
               m_rot = wd[1];
            end
            3'd5: if (int'(wd[2:0]) < N && m_rot) m_ptr = (int'(wd[2:0]) + 1) % N;
            default: ;
         endcase
      end
      m_hw = new_hw;
      smp.push_front(s);
      void'(smp.pop_back());
   endtask

   // One bus cycle; optionally with a hand-derived expectation on the read
   // data and (eh >= 0) on hwirq, sampled during that cycle.
   task automatic cyc(bit r, bit [2:0] a, bit we, bit [31:0] wd,
                      bit hc = 0, bit [31:0] er = 0, int eh = -1, string nm = "");
      exp_t e;
      @(negedge clk);
      rst = r; addr = a; write_enable = we; write_data = wd; irq_src = src_cur;
      e.rd = m_read(a);
      e.hw = m_hw;
      sb.push_back(e);
      if (hc) begin
         #1;
         n_chk++;
         if (read_result !== er) begin
            n_fail++;
            $display("FAIL %s read got %h want %h", nm, read_result, er);
         end
         if (eh >= 0) begin
            n_chk++;
            if (hwirq !== 6'(eh)) begin
               n_fail++;
               $display("FAIL %s hwirq got %h want %h", nm, hwirq, 6'(eh));
            end
         end
      end
      @(posedge clk);
      m_edge(r, a, we, wd, src_cur);
   endtask

   task automatic wr(bit [2:0] a, bit [31:0] wd);
      cyc(0, a, 1, wd);
   endtask

   task automatic chk(bit [2:0] a, bit [31:0] er, int eh, string nm);
      cyc(0, a, 0, 32'd0, 1, er, eh, nm);
   endtask

   task automatic idle(int n);
      repeat (n) cyc(0, 3'd6, 0, 32'd0);
   endtask

   task automatic pulse(bit [5:0] s);
      src_cur = s;
      idle(1);
      src_cur = 6'd0;
   endtask

   task automatic random_phase(int n);
      for (int c = 0; c < n; c++) begin
         bit        r  = ($urandom_range(0, 99) == 0);
         bit [2:0]  a  = 3'($urandom);
         bit        we = ($urandom_range(0, 2) == 0);
         bit [31:0] wd = $urandom;
         if ($urandom_range(0, 3) == 0) src_cur = 6'($urandom);
         cyc(r, a, we, wd);
      end
   endtask

   // Scoreboard monitor: compares every cycle's outputs with the queued model view.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (read_result !== e.rd) begin
               n_fail++;
               $display("FAIL sb_read addr=%0d got %h want %h", addr, read_result, e.rd);
            end
            n_chk++;
            if (hwirq !== e.hw) begin
               n_fail++;
               $display("FAIL sb_hwirq got %h want %h", hwirq, e.hw);
            end
         end
      end
   end

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; addr = '0; write_enable = 1'b0; write_data = '0; irq_src = '0;
      src_cur = '0;
      m_reset();
      cyc(1, 3'd0, 0, 32'd0);
      cyc(1, 3'd0, 0, 32'd0);
      chk(3'd4, 32'd0, 0, "reset_vec");

      random_phase(500);

      // Reset mid-traffic with everything pending.
      src_cur = 6'd0;
      idle(3);
      wr(3'd1, 32'h3F);
      wr(3'd0, 32'h3F);
      pulse(6'h3F);
      idle(1);
      chk(3'd2, 32'h3F, -1, "pre_reset_pend");
      cyc(1, 3'd3, 1, 32'h3);
      cyc(1, 3'd0, 1, 32'hFF);
      for (int a = 0; a < 8; a++) chk(3'(a), 32'd0, 0, "reset_reg");

      // Edge latch latency, W1C, held line.
      wr(3'd1, 32'h3F); wr(3'd0, 32'h01); wr(3'd3, 32'h1);
      pulse(6'h01);
      idle(1);
      chk(3'd2, 32'h01, 0, "edge_pend_e1");
      chk(3'd2, 32'h01, 1, "edge_hw_e2");
      wr(3'd2, 32'h01);
      chk(3'd2, 32'h00, 1, "w1c_pend");
      chk(3'd2, 32'h00, 0, "w1c_hw");
      src_cur = 6'h01;
      idle(2);
      wr(3'd2, 32'h01);
      idle(2);
      chk(3'd2, 32'h00, 0, "held_no_retrig");
      src_cur = 6'h00;
      idle(1);

      // Level mode.
      wr(3'd1, 32'h0); wr(3'd0, 32'h02); wr(3'd3, 32'h1);
      src_cur = 6'h02;
      idle(2);
      chk(3'd2, 32'h02, 2, "level_hw");
      wr(3'd2, 32'h02);
      chk(3'd2, 32'h02, 2, "level_w1c_noeff");
      src_cur = 6'h00;
      idle(1);
      chk(3'd2, 32'h00, 2, "level_drop_e1");
      chk(3'd2, 32'h00, 0, "level_drop_e2");

      // Fixed priority.
      wr(3'd1, 32'h3F); wr(3'd0, 32'h3F);
      pulse(6'h1A);
      idle(1);
      chk(3'd4, 32'h80000001, -1, "fix_vec1");
      wr(3'd5, 32'd1);
      chk(3'd4, 32'h80000003, -1, "fix_vec3");
      wr(3'd5, 32'd3);
      chk(3'd4, 32'h80000004, -1, "fix_vec4");
      wr(3'd5, 32'd4);
      chk(3'd4, 32'h00000000, -1, "fix_vec_none");

      // Rotating priority with wrap and out-of-range ACK.
      wr(3'd3, 32'h3);
      pulse(6'h05);
      idle(1);
      chk(3'd4, 32'h80000000, -1, "rot_vec0");
      wr(3'd5, 32'd0);
      chk(3'd4, 32'h80000002, -1, "rot_vec2");
      pulse(6'h01);
      idle(1);
      chk(3'd4, 32'h80000002, -1, "rot_ptr1_vec2");
      wr(3'd5, 32'd2);
      chk(3'd4, 32'h80000000, -1, "rot_wrap_vec0");
      wr(3'd5, 32'd7);
      chk(3'd4, 32'h80000000, 1, "rot_ack7_ignored");
      wr(3'd5, 32'd0);
      chk(3'd4, 32'h00000000, -1, "rot_empty");
      wr(3'd3, 32'h1);

      // Set/clear collision and masking.
      wr(3'd0, 32'h0);
      wr(3'd2, 32'h3F);
      src_cur = 6'h20;
      idle(1);
      src_cur = 6'h00;
      wr(3'd2, 32'h20);
      chk(3'd2, 32'h20, 0, "collide_set_wins");
      wr(3'd0, 32'h20);
      chk(3'd2, 32'h20, 0, "unmask_e0");
      chk(3'd4, 32'h80000005, 32, "unmask_hw7");

      random_phase(500);

      idle(2);
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain got %0d want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Programmable interrupt controller between device interrupt lines (timer0_irq, timer1_irq, test/external sources) and the CPU's hwirq[7:2] inputs.
- Latches, masks and prioritises up to 6 sources, with edge/level mode per source and fixed or rotating priority.
- Memory-mapped as one more bridge device with the same bus slave port style as timer: word address, write enable, write data, combinational read result.
- Replaces direct wiring of timer irqs into the bridge's hwirq.

Parameters:
- N_SRC, 6, number of sources. Legal range 1..6; source i maps to hwirq[i+2]. Unused hwirq bits are 0.
- SYNC_STAGES, 1, input synchroniser depth. Legal values 1 or 2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- addr  input  3  word address, byte address bits [4:2]
- write_enable  input  1  register write strobe, one cycle per write
- write_data  input  32  write data
- read_result  output  32  combinational read data for addr
- irq_src  input  6  raw device interrupt lines, bit i = source i
- hwirq  output  6  registered interrupt requests to CPU, indexed [7:2]

Behaviour:
- Register map (byte offset):
  - 0x00 MASK: RW, bits[5:0].
  - 0x04 MODE: RW, bit=1 edge, bit=0 level.
  - 0x08 PEND: R, W1C for edge bits.
  - 0x0C CTRL: RW, bit0 EN (global enable), bit1 ROT (rotating priority).
  - 0x10 VEC: R. bit31 = valid, bits[2:0] = selected source.
  - 0x14 ACK: W. write_data[2:0] = source to acknowledge.
  - 0x18, 0x1C: reserved.
- Reads of reserved, write-only or unused bits return 0. Writes to read-only or reserved registers are ignored.
- Reset, with rst sampled high at a clk edge: MASK=0, MODE=0, PEND=0, CTRL=0, priority pointer ptr=0, sync/edge history=0, hwirq=0. This applies mid-operation too: all pending edge events are discarded.
- Synchroniser: src_s is irq_src delayed SYNC_STAGES registers; prev is src_s delayed one more cycle.
- Edge source i:
  - PEND[i] sets on the edge where src_s[i]=1 and prev[i]=0.
  - It clears on a PEND write with bit i=1, or on an ACK with index i.
  - Set and clear in the same cycle: set wins, so no event is lost.
  - A held-high line produces one event only.
- Level source i: PEND[i] = src_s[i] (combinational view). W1C and ACK have no effect on it.
- MODE write switching bit i from level to edge clears PEND[i]. The edge history (prev) is kept, so a line already high does not retrigger.
- eff = PEND & MASK, restricted to bits < N_SRC.
- hwirq <= CTRL.EN ? eff : 0 on every edge, registered.
- Latency, SYNC_STAGES=1, irq_src rising before edge 0:
  - src_s=1 after edge 0.
  - Edge PEND=1 after edge 1.
  - hwirq=1 after edge 2.
  - Level-mode hwirq=1 after edge 1.
  - Each extra sync stage adds one cycle.
- VEC: scan eff starting at index ptr upward, wrapping modulo N_SRC. The first set bit gives the index. valid = (eff != 0) regardless of EN. With no candidate, VEC reads 0.
- ACK with index n < N_SRC:
  - Clears edge PEND[n].
  - If ROT=1, ptr <= (n+1) mod N_SRC. If ROT=0, ptr stays 0.
  - Indices >= N_SRC are ignored entirely, including for ptr.
- Writing ROT 1→0 resets ptr to 0 in the same cycle.
- MASK does not affect PEND latching: masked edge events stay pending and assert hwirq when unmasked.

Decomposition:
- Shared package/header:
  - Register offset constants (IRQ_MASK, IRQ_MODE, IRQ_PEND, IRQ_CTRL, IRQ_VEC, IRQ_ACK).
  - CTRL bit positions.
  - N_SRC maximum of 6.
- One sub-module, irq_rr_select: combinational rotating priority finder taking eff and ptr, producing index and valid. It is reused by any future bus arbiter.
- Edge detect and the register file stay in irq_ctrl.

Test Plan:
1. Reset and idle: assert rst 2 cycles mid-traffic with PEND=0x3F → all registers read 0, hwirq=0, VEC=0x00000000.
2. Edge latch latency: MODE=0x3F, MASK=0x01, CTRL=1; pulse irq_src[0] high 1 cycle → PEND=0x01 after edge 1, hwirq=0x01 after edge 2. W1C PEND 0x01 → hwirq=0 one cycle later. Holding the line high produces no retrigger.
3. Level mode: MODE=0, MASK=0x02, CTRL=1; hold irq_src[1]=1 → hwirq=0x02. W1C has no effect. Drop the line → hwirq=0 two cycles later.
4. Fixed priority: MODE=0x3F, MASK=0x3F, edges on sources 1, 3, 4 → VEC=0x80000001. ACK 1 → VEC=0x80000003. ACK 3 → VEC=0x80000004. ACK 4 → VEC=0.
5. Rotating priority: CTRL=3, sources 0 and 2 pending repeatedly. ACK 0 → VEC selects 2. Re-pend 0, ACK 2 → ptr=3, VEC selects 0 (wrap). ACK 7 is ignored.
6. Collision and masking: W1C PEND bit 5 in the same cycle as a new edge on 5 → PEND[5] stays 1. With MASK=0 → hwirq=0 but PEND=0x20. Set MASK=0x20 → hwirq[7]=1 next cycle.
